// File: rtl/l2_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : l2_bus_pkg / l2_bus_arbiter_if
// Brief  : L1<->L2 transfer types and the bundled bus seen by the arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package l2_bus_pkg;
  typedef struct packed {
    logic        Valid;
    logic        Wen;
    logic        Src;
    logic [31:0] Addr;
    logic [31:0] WriteD;
  } L1ToL2_t;

  typedef struct packed {
    logic        Ready;
    logic        Dst;
    logic [31:0] ReadD;
  } L2ToL1_t;
endpackage

interface l2_bus_arbiter_if;
  import l2_bus_pkg::*;

  L1ToL2_t InstrReq_i;
  L1ToL2_t DataReq_i;
  L2ToL1_t L2Resp_i;
  L1ToL2_t L2Req_o;
  L1ToL2_t Bus_o;
  L2ToL1_t InstrResp_o;
  L2ToL1_t DataResp_o;

  modport master (
    input  InstrReq_i,
    input  DataReq_i,
    input  L2Resp_i,
    output L2Req_o,
    output Bus_o,
    output InstrResp_o,
    output DataResp_o
  );

  modport slave (
    output InstrReq_i,
    output DataReq_i,
    output L2Resp_i,
    input  L2Req_o,
    input  Bus_o,
    input  InstrResp_o,
    input  DataResp_o
  );
endinterface
`default_nettype wire

// File: rtl/l2_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : l2_bus_arbiter
// Brief  : Shares the L1->L2 bus between instr (Src=0) and data (Src=1) caches.
//          Define ARB_ROUND_ROBIN_EN for round-robin tie-break instead of PRIO_DATA.
// Rev    : 1.0  initial release
// ============================================================================
module l2_bus_arbiter
  import l2_bus_pkg::*;
#(
  parameter bit PRIO_DATA = 1'b1,
  parameter int MAX_HOLD  = 64
) (
  input  wire              clk_i,
  input  wire              rst_i,
  l2_bus_arbiter_if.master bus,
  output logic             err_o
);
  localparam int                 c_cnt_w    = $clog2(MAX_HOLD + 1);
  localparam logic [c_cnt_w-1:0] c_hold_max = c_cnt_w'(MAX_HOLD);

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_grant   = 2'd1;
  localparam logic [1:0] c_st_release = 2'd2;

  logic [1:0]         r_state, w_state_nxt;
  logic               r_owner, w_owner_nxt;
  logic               r_last;
  logic               r_err;
  logic [c_cnt_w-1:0] r_hold, w_hold_nxt;
  logic               w_tie_pick;
  L1ToL2_t            w_own_req, w_req;
  L2ToL1_t            w_iresp, w_dresp;
  logic [2:0]         w_unused_fields;

`ifdef ARB_ROUND_ROBIN_EN
  logic w_unused_prio;
  assign w_tie_pick    = ~r_last;
  assign w_unused_prio = PRIO_DATA;
`else
  logic w_unused_last;
  assign w_tie_pick    = PRIO_DATA;
  assign w_unused_last = r_last;
`endif

  // Incoming Src/Dst fields are replaced by the arbiter's own view of ownership
  assign w_unused_fields = {bus.L2Resp_i.Dst, bus.InstrReq_i.Src, bus.DataReq_i.Src};

  assign w_own_req  = r_owner ? bus.DataReq_i : bus.InstrReq_i;
  assign w_hold_nxt = (r_hold == c_hold_max) ? r_hold : r_hold + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    case (r_state)
      c_st_idle: begin
        if (bus.InstrReq_i.Valid || bus.DataReq_i.Valid) begin
          w_state_nxt = c_st_grant;
          if (bus.InstrReq_i.Valid && bus.DataReq_i.Valid) w_owner_nxt = w_tie_pick;
          else                                             w_owner_nxt = bus.DataReq_i.Valid;
        end
      end
      c_st_grant: begin
        if (bus.L2Resp_i.Ready || !w_own_req.Valid) w_state_nxt = c_st_release;
      end
      c_st_release: w_state_nxt = c_st_idle;
      default:      w_state_nxt = c_st_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= c_st_idle;
      r_owner <= 1'b0;
      r_hold  <= '0;
      r_err   <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      if (r_state == c_st_grant) begin
        r_hold <= w_hold_nxt;
        if (w_hold_nxt == c_hold_max) r_err <= 1'b1;
      end else if (r_state == c_st_release) begin
        r_hold <= '0;
        r_last <= r_owner;
      end
    end
  end

  // Only GRANT drives the bus or forwards a response; everything else is idle
  always_comb begin
    w_req   = '0;
    w_iresp = '0;
    w_dresp = '0;
    if (r_state == c_st_grant) begin
      w_req     = w_own_req;
      w_req.Src = r_owner;
      if (bus.L2Resp_i.Ready) begin
        if (r_owner) begin
          w_dresp.Ready = 1'b1;
          w_dresp.Dst   = 1'b1;
          w_dresp.ReadD = bus.L2Resp_i.ReadD;
        end else begin
          w_iresp.Ready = 1'b1;
          w_iresp.Dst   = 1'b0;
          w_iresp.ReadD = bus.L2Resp_i.ReadD;
        end
      end
    end
  end

  assign bus.L2Req_o     = w_req;
  assign bus.Bus_o       = w_req;
  assign bus.InstrResp_o = w_iresp;
  assign bus.DataResp_o  = w_dresp;
  assign err_o           = r_err;

endmodule
`default_nettype wire
